// File: rtl/cdc_in_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one usb_cdc IN channel between byte-stream requesters.
// Latency: grant 1 cycle after valid is seen in IDLE; an accepted byte appears on out_data_o the next cycle.
// Backpressure: out_ready_i low holds the output register and forces req_ready_o low; stalls neither count nor end a burst.
// Build option: define CDC_IN_ARBITER_TAG_EN to prefix every burst with tag byte 8'hA0 | grantee index.
module cdc_in_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int BURST_LEN  = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [8*REQUESTERS-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]   req_valid_i,
    output logic [REQUESTERS-1:0]   req_ready_o,
    output logic [7:0]              out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [REQUESTERS-1:0]   grant_o
);

    localparam int IDX_W = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(REQUESTERS - 1);

`ifdef CDC_IN_ARBITER_TAG_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_DATA = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd2
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [REQUESTERS-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             out_dat_q, out_dat_d;
    logic                   out_vld_q, out_vld_d;

    logic                   slot_free;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [REQUESTERS-1:0]  sel_onehot;
    int                     scan_d;
    int                     best_d;
    logic                   cur_vld;
    logic [7:0]             cur_dat;
    logic                   accept;
    logic [CNT_W-1:0]       cnt_inc;

    assign slot_free   = ~out_vld_q | out_ready_i;
    assign cnt_inc     = cnt_q + 1'b1;
    assign out_data_o  = out_dat_q;
    assign out_valid_o = out_vld_q;
    assign grant_o     = grant_q;

    // Round-robin pick: the valid requester at the smallest distance after the last winner.
    always_comb begin
        best_d     = REQUESTERS;
        scan_d     = 0;
        sel_idx    = '0;
        sel_onehot = '0;
        sel_found  = |req_valid_i;
        for (int c = 0; c < REQUESTERS; c++) begin
            scan_d = (c + REQUESTERS - 1 - int'(last_q)) % REQUESTERS;
            if (req_valid_i[c] && (scan_d < best_d)) begin
                best_d  = scan_d;
                sel_idx = IDX_W'(c);
            end
        end
        for (int c = 0; c < REQUESTERS; c++) begin
            sel_onehot[c] = (IDX_W'(c) == sel_idx);
        end
    end

    // Route the current grantee's byte and valid.
    always_comb begin
        cur_vld = 1'b0;
        cur_dat = 8'h00;
        for (int c = 0; c < REQUESTERS; c++) begin
            if (gidx_q == IDX_W'(c)) begin
                cur_vld = req_valid_i[c];
                cur_dat = req_data_i[c*8 +: 8];
            end
        end
    end

    // Next-state logic: arbitration FSM plus an output register that drains independently.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_dat_d   = out_dat_q;
        out_vld_d   = out_vld_q;
        req_ready_o = '0;
        accept      = 1'b0;

        if (out_vld_q && out_ready_i) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d = sel_onehot;
                    gidx_d  = sel_idx;
                    cnt_d   = '0;
`ifdef CDC_IN_ARBITER_TAG_EN
                    state_d = ST_TAG;
`else
                    state_d = ST_DATA;
`endif
                end
            end
`ifdef CDC_IN_ARBITER_TAG_EN
            ST_TAG: begin
                // Tag byte goes out ahead of the payload and is not counted.
                if (slot_free) begin
                    out_dat_d = 8'hA0 | 8'(gidx_q);
                    out_vld_d = 1'b1;
                    state_d   = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                req_ready_o = grant_q & {REQUESTERS{slot_free}};
                accept      = cur_vld & slot_free;
                if (accept) begin
                    out_dat_d = cur_dat;
                    out_vld_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_inc;
                    end
                end
                // End on the BURST_LEN-th byte, or when the grantee goes idle with room available.
                if ((accept && (cnt_inc == CNT_MAX)) || (slot_free && !cur_vld)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // All state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            out_dat_q <= 8'h00;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
module tb_cdc_in_arbiter;

    localparam int R  = 2;
    localparam int BL = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic [8*R-1:0] req_data;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_ready;
    logic [R-1:0]   grant;

    always #5 clk = ~clk;

    cdc_in_arbiter #(.REQUESTERS(R), .BURST_LEN(BL)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .grant_o     (grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester drivers ----------------
    int           rem [R];
    int           nxt [R];
    logic [7:0]   base [R];
    bit           rnd_mode;
    logic [R-1:0] acc_drv;

    task automatic drive_inputs();
        for (int k = 0; k < R; k++) begin
            req_valid[k] = (rem[k] > 0) && (!rnd_mode || ($urandom_range(0, 3) != 0));
            req_data[8*k +: 8] = base[k] | 8'(nxt[k] & 127);
        end
        out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < R; k++) begin
            if (acc_drv[k]) begin
                nxt[k]++;
                rem[k]--;
            end
        end
        drive_inputs();
    endtask

    // ---------------- reference model (rule level) ----------------
    bit           mon_en = 0;
    logic [7:0]   exp_q [$];
    logic [7:0]   cap_q [$];
    int           fall_q [$];
    int           gap_q [$];
    int           last_m, cnt_m, acc_total, gap;
    logic [R-1:0] exp_g;
    bit           tag_pending;
    bit           prev_stall;
    logic [7:0]   prev_od;

    function automatic int pick(input logic [R-1:0] v, input int last);
        for (int d = 1; d <= R; d++) begin
            if (v[(last + d) % R]) return (last + d) % R;
        end
        return 0;
    endfunction

    function automatic int idx_of(input logic [R-1:0] g);
        for (int k = 0; k < R; k++) begin
            if (g[k]) return k;
        end
        return 0;
    endfunction

    task automatic monitor_step();
        bit sf;
        int gi;
        sf = !out_valid || out_ready;
        chk("grant", grant, exp_g);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_od);
        end
        if (out_valid && out_ready) begin
            cap_q.push_back(out_data);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream: got unexpected byte 0x%0h expected none", out_data);
            end else begin
                chk("stream", out_data, exp_q.pop_front());
            end
        end
        if (exp_g == '0) begin
            chk("ready_idle", req_ready, 0);
            gap++;
            if (req_valid != '0) begin
                gi    = pick(req_valid, last_m);
                exp_g = R'(1) << gi;
                cnt_m = 0;
                gap_q.push_back(gap);
                gap   = 0;
`ifdef CDC_IN_ARBITER_TAG_EN
                tag_pending = 1;
                exp_q.push_back(8'hA0 | 8'(gi));
`endif
            end
        end else begin
            gi = idx_of(exp_g);
            if (tag_pending) begin
                chk("ready_tag", req_ready, 0);
                if (sf) tag_pending = 0;
            end else begin
                chk("ready_data", req_ready, sf ? int'(exp_g) : 0);
                if (req_valid[gi] && sf) begin
                    exp_q.push_back(req_data[8*gi +: 8]);
                    cnt_m++;
                    acc_total++;
                end
                if ((req_valid[gi] && sf && cnt_m == BL) || (sf && !req_valid[gi])) begin
                    fall_q.push_back(acc_total);
                    last_m = gi;
                    exp_g  = '0;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_od    = out_data;
    endtask

    always @(negedge clk) begin
        acc_drv = req_valid & req_ready;
        if (mon_en) monitor_step();
    end

    // ---------------- helpers ----------------
    task automatic clear_drivers();
        rnd_mode  = 0;
        for (int k = 0; k < R; k++) begin
            rem[k]  = 0;
            nxt[k]  = 0;
            base[k] = 8'h00;
        end
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    task automatic do_reset();
        mon_en = 0;
        rstn   = 1'b0;
        clear_drivers();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rstn = 1'b1;
        exp_q.delete();
        cap_q.delete();
        fall_q.delete();
        gap_q.delete();
        last_m      = R - 1;
        cnt_m       = 0;
        acc_total   = 0;
        gap         = 0;
        exp_g       = '0;
        tag_pending = 0;
        prev_stall  = 0;
        mon_en      = 1;
    endtask

    task automatic cmp_capture(input string name, input logic [7:0] expv [$]);
        chk({name, "_count"}, cap_q.size(), expv.size());
        for (int i = 0; i < expv.size() && i < cap_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), cap_q[i], expv[i]);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic [1:0] g;
        logic [1:0] r;
        logic       ov;
        logic [7:0] od;
    } vec_t;

    vec_t tbl [16];

    logic [7:0] expv [$];

    initial begin
        // {v0, d0, v1, d1, out_ready | grant, ready, out_valid, out_data}
        tbl[0]  = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h10};
        tbl[3]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h10};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h10};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 8'h10};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 2'b01, 2'b01, 1'b1, 8'h11};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 2'b00, 2'b00, 1'b0, 8'h11};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h20, 1'b1, 2'b10, 2'b10, 1'b0, 8'h11};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h21, 1'b1, 2'b10, 2'b10, 1'b1, 8'h20};
        tbl[10] = '{1'b1, 8'h12, 1'b1, 8'h22, 1'b1, 2'b10, 2'b10, 1'b1, 8'h21};
        tbl[11] = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 2'b10, 2'b10, 1'b1, 8'h22};
        tbl[12] = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h22};
        tbl[13] = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 2'b01, 2'b01, 1'b0, 8'h22};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b01, 2'b01, 1'b1, 8'h12};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h12};

        rstn = 1'b0;
        clear_drivers();

`ifndef CDC_IN_ARBITER_TAG_EN
        // Backpressure, valid-without-ready and early release, cycle by cycle.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req_valid = {tbl[i].v1, tbl[i].v0};
            req_data  = {tbl[i].d1, tbl[i].d0};
            out_ready = tbl[i].ordy;
            #3;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].r);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
            @(posedge clk);
            #1;
        end
`endif

        // Single requester: 20 bytes, bursts of 8 with one idle cycle between.
        do_reset();
        rem[0] = 20;
        drive_inputs();
        expv.delete();
        for (int i = 0; i < 20; i++) begin
`ifdef CDC_IN_ARBITER_TAG_EN
            if (i % BL == 0) expv.push_back(8'hA0);
`endif
            expv.push_back(8'(i));
        end
        for (int c = 0; c < 80 && cap_q.size() < expv.size(); c++) cycle();
        cmp_capture("single", expv);
        if (fall_q.size() >= 2 && gap_q.size() >= 3) begin
            chk("single_end1", fall_q[0], 8);
            chk("single_end2", fall_q[1], 16);
            chk("single_gap1", gap_q[1], 1);
            chk("single_gap2", gap_q[2], 1);
        end else begin
            checks++;
            errors++;
            $display("FAIL single_bursts: got %0d ends expected at least 2", fall_q.size());
        end

        // Contention: both requesters stream, bursts alternate in units of BL.
        do_reset();
        rem[0]  = 16;
        rem[1]  = 16;
        base[1] = 8'h80;
        drive_inputs();
        expv.delete();
        for (int b = 0; b < 4; b++) begin
`ifdef CDC_IN_ARBITER_TAG_EN
            expv.push_back(8'hA0 | 8'(b % 2));
`endif
            for (int j = 0; j < BL; j++) expv.push_back(base[b % 2] | 8'((b / 2) * BL + j));
        end
        for (int c = 0; c < 120 && cap_q.size() < expv.size(); c++) cycle();
        cmp_capture("contend", expv);

        // Reset mid-burst: outputs clear asynchronously and the pointer returns to R-1.
        do_reset();
        rem[0] = 30;
        drive_inputs();
        for (int c = 0; c < 60 && acc_total < BL + 3; c++) cycle();
        chk("midburst_reached", (acc_total >= BL + 3) ? 1 : 0, 1);
        chk("midburst_busy", out_valid, 1);
        mon_en = 0;
        rstn   = 1'b0;
        #2;
        chk_reset_outputs("async");
        do_reset();
        rem[0]  = 4;
        rem[1]  = 4;
        base[1] = 8'h80;
        drive_inputs();
        for (int c = 0; c < 10 && grant == '0; c++) cycle();
        chk("post_reset_grant", grant, 1);

        // Randomized valids and output stalls against the rule-level model.
        do_reset();
        rnd_mode = 1;
        rem[0]   = 100000;
        rem[1]   = 100000;
        base[1]  = 8'h80;
        drive_inputs();
        for (int c = 0; c < 3000; c++) cycle();
        rnd_mode = 0;
        rem[0]   = 0;
        rem[1]   = 0;
        for (int c = 0; c < 20; c++) cycle();
        chk("drain_empty", exp_q.size(), 0);
        chk("random_traffic", (cap_q.size() > 500) ? 1 : 0, 1);

        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
